// File: rtl/multicycle_adder_if.sv
// Start/busy/done handshake and operand/result bus of the multi-cycle add/subtract unit.
// The controlling FSM uses master; the adder uses slave.
interface multicycle_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/multicycle_adder.sv
// Multi-cycle add/subtract: one DIGIT-bit ripple slice with a registered carry.
// It processes the LSB digit first and finishes in WIDTH/DIGIT cycles.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_adder_if.slave bus
);

  localparam int K     = WIDTH / DIGIT;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             done_r;

  logic [DIGIT:0]   slice;
  logic             msb_cin;
  logic             last;
  logic [WIDTH-1:0] result;

  always_comb begin
    slice   = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Carry into the top bit of this digit; meaningful on the final digit only.
    msb_cin = opa[DIGIT-1] ^ opb[DIGIT-1] ^ slice[DIGIT-1];
    last    = (cnt == CNT_W'(K - 1));
  end

  // Partial sum holds the K-1 digits already produced; the live slice completes the word.
  generate
    if (K == 1) begin : g_single
      assign result = slice[DIGIT-1:0];
    end else begin : g_multi
      logic [WIDTH-DIGIT-1:0] psum;

      assign result = {slice[DIGIT-1:0], psum};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          psum <= '0;
        end else if (state == RUN) begin
          psum <= result[WIDTH-1:DIGIT];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa   <= bus.a;
            opb   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          carry <= slice[DIGIT];
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            sum_r  <= result;
            cout_r <= slice[DIGIT];
            ovf_r  <= msb_cin ^ slice[DIGIT];
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule
